// File: rtl/tetris_move_scheduler_pkg.sv
// rtl/tetris_move_scheduler_pkg.sv - shared command/state encodings for the move scheduler
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE     = 3'd0,
    CMD_LEFT     = 3'd1,
    CMD_RIGHT    = 3'd2,
    CMD_ROTATE   = 3'd3,
    CMD_SOFTDROP = 3'd4,
    CMD_GRAVITY  = 3'd5
  } move_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_ISSUE = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic rotate;
    logic left;
    logic right;
    logic softdrop;
    logic gravity;
  } pending_t;

  // Fixed priority: rotate first so a spin is never starved by a held direction key.
  function automatic move_cmd_e pick_cmd(input pending_t p);
    if (p.rotate)        return CMD_ROTATE;
    else if (p.left)     return CMD_LEFT;
    else if (p.right)    return CMD_RIGHT;
    else if (p.softdrop) return CMD_SOFTDROP;
    else if (p.gravity)  return CMD_GRAVITY;
    else                 return CMD_NONE;
  endfunction

endpackage

// File: rtl/tetris_move_scheduler_if.sv
// rtl/tetris_move_scheduler_if.sv - req/ack command channel between scheduler and grid datapath
interface tetris_move_if;
  logic       O_MOVE_REQ;
  logic [2:0] O_MOVE_CMD;
  logic       I_MOVE_ACK;
  logic       I_MOVE_OK;

  modport master (output O_MOVE_REQ, output O_MOVE_CMD, input I_MOVE_ACK, input I_MOVE_OK);
  modport slave  (input O_MOVE_REQ, input O_MOVE_CMD, output I_MOVE_ACK, output I_MOVE_OK);
endinterface

// File: rtl/tetris_move_scheduler_key_repeat.sv
// rtl/tetris_move_scheduler_key_repeat.sv - key synchronizer with frame-based edge/auto-repeat detect
module key_repeat #(
  parameter int MOVE_DELAY = 3,
  parameter bit REPEAT     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic frame_end,
  output logic fire
);

  localparam int CW = $clog2(MOVE_DELAY + 1);
  localparam logic [CW-1:0] RELOAD = CW'(MOVE_DELAY - 1);

  logic          sync_1;
  logic          key_held;
  logic          held_prev;
  logic [CW-1:0] rep_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1    <= 1'b0;
      key_held  <= 1'b0;
      held_prev <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      sync_1   <= key_raw;
      key_held <= sync_1;
      if (frame_end) begin
        held_prev <= key_held;
        if (!key_held)
          rep_cnt <= '0;
        else if (rep_cnt == '0)
          rep_cnt <= RELOAD;
        else
          rep_cnt <= rep_cnt - 1'b1;
      end
    end
  end

  // Repeat keys fire whenever the countdown is exhausted; edge keys only on a fresh press.
  assign fire = frame_end && key_held && (REPEAT ? (rep_cnt == '0) : !held_prev);

endmodule

// File: rtl/tetris_move_scheduler.sv
// rtl/tetris_move_scheduler.sv - frame-synchronous key/gravity arbiter issuing grid moves over req/ack
module tetris_move_scheduler
  import tetris_pkg::*;
#(
  parameter int MOVE_DELAY     = 3,
  parameter int GRAVITY_FRAMES = 30
) (
  input  logic I_50MHZ_CLK,
  input  logic I_RESET,
  input  logic I_FRAME_END,
  input  logic I_KEY_UP,
  input  logic I_KEY_DOWN,
  input  logic I_KEY_LEFT,
  input  logic I_KEY_RIGHT,
  tetris_move_if.master move_bus,
  output logic O_LOCK,
  output logic O_BUSY
);

  localparam int GW = $clog2(GRAVITY_FRAMES + 1);
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_FRAMES - 1);

  logic fire_up, fire_down, fire_left, fire_right;

  key_repeat #(.MOVE_DELAY(MOVE_DELAY), .REPEAT(1'b0)) u_key_up (
    .clk(I_50MHZ_CLK), .rst(I_RESET), .key_raw(I_KEY_UP), .frame_end(I_FRAME_END), .fire(fire_up));
  key_repeat #(.MOVE_DELAY(MOVE_DELAY), .REPEAT(1'b1)) u_key_down (
    .clk(I_50MHZ_CLK), .rst(I_RESET), .key_raw(I_KEY_DOWN), .frame_end(I_FRAME_END), .fire(fire_down));
  key_repeat #(.MOVE_DELAY(MOVE_DELAY), .REPEAT(1'b1)) u_key_left (
    .clk(I_50MHZ_CLK), .rst(I_RESET), .key_raw(I_KEY_LEFT), .frame_end(I_FRAME_END), .fire(fire_left));
  key_repeat #(.MOVE_DELAY(MOVE_DELAY), .REPEAT(1'b1)) u_key_right (
    .clk(I_50MHZ_CLK), .rst(I_RESET), .key_raw(I_KEY_RIGHT), .frame_end(I_FRAME_END), .fire(fire_right));

  sched_state_e  state_q, state_nx;
  move_cmd_e     cmd_q, cmd_nx;
  pending_t      pend_q, pend_nx;
  logic [GW-1:0] grav_cnt;
  logic          lock_q;

  logic ack_take, drop_cmd, lock_ev, soft_ok, grav_wrap;

  assign ack_take  = (state_q == ST_ISSUE) && move_bus.I_MOVE_ACK;
  assign drop_cmd  = (cmd_q == CMD_SOFTDROP) || (cmd_q == CMD_GRAVITY);
  assign lock_ev   = ack_take && drop_cmd && !move_bus.I_MOVE_OK;
  assign soft_ok   = ack_take && (cmd_q == CMD_SOFTDROP) && move_bus.I_MOVE_OK;
  assign grav_wrap = I_FRAME_END && (grav_cnt == GRAV_LAST);

  always_comb begin
    pend_nx = pend_q;
    if (ack_take) begin
      case (cmd_q)
        CMD_ROTATE:   pend_nx.rotate   = 1'b0;
        CMD_LEFT:     pend_nx.left     = 1'b0;
        CMD_RIGHT:    pend_nx.right    = 1'b0;
        CMD_SOFTDROP: pend_nx.softdrop = 1'b0;
        CMD_GRAVITY:  pend_nx.gravity  = 1'b0;
        default: ;
      endcase
      if (soft_ok)
        pend_nx.gravity = 1'b0;
      if (lock_ev) begin
        pend_nx.softdrop = 1'b0;
        pend_nx.gravity  = 1'b0;
        pend_nx.left     = 1'b0;
        pend_nx.right    = 1'b0;
      end
    end
    // Sets are applied after clears so a fresh eligibility in the ack cycle is not lost.
    if (fire_up)                  pend_nx.rotate   = 1'b1;
    if (fire_left && !fire_right) pend_nx.left     = 1'b1;
    if (fire_right && !fire_left) pend_nx.right    = 1'b1;
    if (fire_down)                pend_nx.softdrop = 1'b1;
    if (grav_wrap)                pend_nx.gravity  = 1'b1;
  end

  always_comb begin
    state_nx = state_q;
    cmd_nx   = cmd_q;
    case (state_q)
      ST_IDLE:  if (I_FRAME_END) state_nx = ST_ARB;
      ST_ARB: begin
        if (pend_q != '0) begin
          state_nx = ST_ISSUE;
          cmd_nx   = pick_cmd(pend_q);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ISSUE: if (move_bus.I_MOVE_ACK) state_nx = ST_ARB;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_50MHZ_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_NONE;
      pend_q   <= '0;
      grav_cnt <= '0;
      lock_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      cmd_q   <= cmd_nx;
      pend_q  <= pend_nx;
      lock_q  <= lock_ev;
      if (lock_ev || soft_ok)
        grav_cnt <= '0;
      else if (I_FRAME_END)
        grav_cnt <= grav_wrap ? '0 : grav_cnt + 1'b1;
    end
  end

  assign move_bus.O_MOVE_REQ = (state_q == ST_ISSUE);
  assign move_bus.O_MOVE_CMD = cmd_q;
  assign O_LOCK              = lock_q;
  assign O_BUSY              = (state_q != ST_IDLE);

endmodule

// File: doc/tetris_move_scheduler.md
# tetris_move_scheduler

Frame-synchronous move scheduler for the Tetris grid datapath. Once per displayed frame it gathers player key requests and the gravity timer, then arbitrates them by fixed priority. Winning commands go to the grid-update logic one at a time over a req/ack handshake, and the scheduler signals piece lock when a downward move is refused. It sits between the key inputs, the VGA frame-end strobe and the grid/piece datapath, and replaces ad-hoc per-key move logic.

## Interface
- MOVE_DELAY, 3: frames between auto-repeats of a held LEFT/RIGHT/DOWN key (≥1)
- GRAVITY_FRAMES, 30: frames between automatic gravity drops (≥1)
- I_50MHZ_CLK  in  1  system clock; all logic on rising edge
- I_RESET  in  1  asynchronous, active-high reset
- I_FRAME_END  in  1  one-cycle strobe, end of visible frame (draw finished)
- I_KEY_UP / I_KEY_DOWN / I_KEY_LEFT / I_KEY_RIGHT  in  1 each  raw asynchronous keys, active-high
- O_MOVE_REQ  out  1  command valid; held until acked
- O_MOVE_CMD  out  3  0 NONE, 1 LEFT, 2 RIGHT, 3 ROTATE, 4 SOFTDROP, 5 GRAVITY; stable while O_MOVE_REQ
- I_MOVE_ACK  in  1  datapath accepted/evaluated command (one cycle)
- I_MOVE_OK  in  1  valid with I_MOVE_ACK: 1 = move applied, 0 = blocked
- O_LOCK  out  1  one-cycle pulse: piece landed (SOFTDROP/GRAVITY blocked)
- O_BUSY  out  1  state ≠ IDLE

## Operation
- Keys pass a 2-FF synchronizer; all key decisions use synchronized values, sampled only on I_FRAME_END.
- Per frame end, per key (LEFT, RIGHT, DOWN): held and rep_cnt==0 → set pending bit, rep_cnt=MOVE_DELAY-1; held and rep_cnt>0 → rep_cnt-1; released → rep_cnt=0. First press therefore fires on the first frame end seen held.
- UP (rotate): edge only; pending set when held now and not held at previous frame end; no repeat.
- LEFT and RIGHT both eligible in the same frame: neither is set pending; both rep_cnt still reload.
- Gravity: grav_cnt counts frame ends 0..GRAVITY_FRAMES-1; on wrap sets gravity pending. An accepted SOFTDROP (ack with OK) clears grav_cnt to 0 and clears gravity pending.
- Pending bits are sticky ORs: re-eligibility while already pending does not queue twice.
- FSM: IDLE → (I_FRAME_END) ARB. ARB: pick highest pending, ROTATE > LEFT > RIGHT > SOFTDROP > GRAVITY → ISSUE; none pending → IDLE. ISSUE: O_MOVE_REQ=1 with cmd; on I_MOVE_ACK clear that bit → ARB.
- Ack of SOFTDROP/GRAVITY with I_MOVE_OK=0: O_LOCK pulse; clear SOFTDROP, GRAVITY and LEFT/RIGHT pending; grav_cnt=0.
- I_FRAME_END while O_BUSY: counters and pending bits update normally; FSM is not restarted. New pending bits are served in the current ARB loop.
- I_MOVE_ACK outside ISSUE is ignored.

## Timing
- Reset: O_MOVE_REQ=0, O_MOVE_CMD=0, O_LOCK=0, O_BUSY=0, FSM IDLE, all pending, rep_cnt and grav_cnt 0, synchronizers 0. Reset mid-handshake drops O_MOVE_REQ immediately (async).
- Key edge to synchronized value: 2 cycles.
- I_FRAME_END at cycle n → ARB at n+1 → O_MOVE_REQ high at n+2 (registered outputs).
- Ack at cycle k → O_MOVE_REQ low and O_LOCK (if any) high at k+1. The next command's REQ rises at k+2 earliest. Ack in the same cycle REQ rises is legal.
- Counter widths: $clog2(MOVE_DELAY+1), $clog2(GRAVITY_FRAMES+1); no overflow beyond the parameter values.

## Structure
- Shared package tetris_pkg: cmd encoding constants (CMD_NONE..CMD_GRAVITY), FSM state encoding.
- Sub-module key_repeat (sync + edge + repeat counter, parameter MOVE_DELAY, REPEAT enable); instantiated four times (UP with REPEAT=0).

## Test plan
- Reset then 30 idle frames, GRAVITY_FRAMES=30, ack OK after 1 cycle → exactly one CMD 5 request, REQ at frame-end+2, no O_LOCK.
- LEFT held frames 4–14, MOVE_DELAY=3 → LEFT issued at frames 4, 7, 10, 13 only.
- UP, LEFT and DOWN become eligible on the same frame → order 3, 1, 4; one REQ each; REQ low one cycle between them.
- LEFT and RIGHT pressed in the same frame → no LEFT/RIGHT command that frame.
- GRAVITY acked with I_MOVE_OK=0 → single O_LOCK pulse the cycle after ack; pending SOFTDROP discarded.
- I_RESET asserted while REQ high awaiting ack → REQ=0 asynchronously; after release no command until next eligible frame end.
